// File: rtl/add_result_stage.sv
// add_result_stage
// Registered result stage behind a ripple-carry adder lane. It derives the
// unsigned carry/borrow and signed overflow flags, and optionally saturates
// the sum (unsigned or signed). A two-entry skid buffer gives one-cycle
// latency at full throughput with a registered in_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   in_sum, in_cout,         adder sum, carry out, carry into the MSB
//   in_prev_cout
//   in_sub                   beat is a subtract (upstream fed ~B, cin=1)
//   in_mode                  00 wrap, 01 unsigned sat, 10 signed sat, 11 wrap
//   out_valid / out_ready    downstream handshake
//   out_result               final, possibly saturated, result
//   out_carry, out_ovf       carry (add) or borrow (sub), signed overflow
//   out_zero, out_neg        flags of the final result
//   out_sat                  this beat was saturated
//   vxsat_clr / vxsat        sticky saturation flag and its clear
module add_result_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_prev_cout,
  input  logic             in_sub,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_sat,
  input  logic             vxsat_clr,
  output logic             vxsat
);

  typedef enum logic [1:0] {
    MODE_WRAP = 2'b00,
    MODE_USAT = 2'b01,
    MODE_SSAT = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;
    logic             sat;
  } beat_t;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  beat_t new_beat;
  beat_t out_q;
  beat_t skid_q;
  logic  out_valid_q;
  logic  skid_valid_q;
  logic  vxsat_q;
  logic  accept;
  logic  transfer;

  assign accept   = in_valid && in_ready;
  assign transfer = out_valid_q && out_ready;

  // Flags come from the raw adder outputs; zero/neg are taken from the
  // result after saturation. A subtract borrows when the adder did not carry.
  always_comb begin
    new_beat        = '0;
    new_beat.result = in_sum;
    new_beat.carry  = in_sub ? ~in_cout : in_cout;
    new_beat.ovf    = in_cout ^ in_prev_cout;
    case (mode_e'(in_mode))
      MODE_USAT: begin
        if (new_beat.carry) begin
          new_beat.result = in_sub ? '0 : '1;
          new_beat.sat    = 1'b1;
        end
      end
      MODE_SSAT: begin
        // A wrapped negative sum means the true result overflowed upward.
        if (new_beat.ovf) begin
          new_beat.result = in_sum[WIDTH-1] ? MAX_POS : MIN_NEG;
          new_beat.sat    = 1'b1;
        end
      end
      default: ;
    endcase
    new_beat.zero = (new_beat.result == '0);
    new_beat.neg  = new_beat.result[WIDTH-1];
  end

  // Skid buffer. The skid entry is only ever occupied while the output entry
  // is, and in_ready is low while it is, so a refill from skid never competes
  // with a new upstream beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (!out_valid_q || transfer) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= new_beat;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= new_beat;
      skid_valid_q <= 1'b1;
    end
  end

  // Sticky saturation: a saturating transfer takes priority over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      vxsat_q <= 1'b0;
    end else if (transfer && out_q.sat) begin
      vxsat_q <= 1'b1;
    end else if (vxsat_clr) begin
      vxsat_q <= 1'b0;
    end
  end

  assign in_ready   = ~skid_valid_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_q.result;
  assign out_carry  = out_q.carry;
  assign out_ovf    = out_q.ovf;
  assign out_zero   = out_q.zero;
  assign out_neg    = out_q.neg;
  assign out_sat    = out_q.sat;
  assign vxsat      = vxsat_q;

endmodule

// File: tb/tb_add_result_stage.sv
// tb_add_result_stage
// Drives operand pairs through a modelled ripple-carry adder into
// add_result_stage and compares every cycle against a queue-based model that
// computes results from true integer arithmetic, plus literal checks for the
// directed scenarios.
module tb_add_result_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sum;
  logic       in_cout;
  logic       in_prev_cout;
  logic       in_sub;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_carry;
  logic       out_ovf;
  logic       out_zero;
  logic       out_neg;
  logic       out_sat;
  logic       vxsat_clr;
  logic       vxsat;

  logic [7:0] cur_a;
  logic [7:0] cur_b;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] result;
    logic       carry;
    logic       ovf;
    logic       zero;
    logic       neg;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  logic model_vxsat = 1'b0;
  logic primed      = 1'b0;

  add_result_stage #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_cout      (in_cout),
    .in_prev_cout (in_prev_cout),
    .in_sub       (in_sub),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_ovf      (out_ovf),
    .out_zero     (out_zero),
    .out_neg      (out_neg),
    .out_sat      (out_sat),
    .vxsat_clr    (vxsat_clr),
    .vxsat        (vxsat)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream adder: A + B, or A + ~B + 1 for a subtract.
  task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [7:0] b,
                               input logic sub, input logic [1:0] mode,
                               input logic ordy, input logic clr);
    logic [7:0] b_eff;
    logic [8:0] full;
    logic [7:0] low;
    b_eff        = sub ? ~b : b;
    full         = {1'b0, a} + {1'b0, b_eff} + {8'd0, sub};
    low          = {1'b0, a[6:0]} + {1'b0, b_eff[6:0]} + {7'd0, sub};
    cur_a        = a;
    cur_b        = b;
    in_valid     = valid;
    in_sum       = full[7:0];
    in_cout      = full[8];
    in_prev_cout = low[7];
    in_sub       = sub;
    in_mode      = mode;
    out_ready    = ordy;
    vxsat_clr    = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beat from integer arithmetic on the original operands.
  function automatic exp_t modelBeat(input logic [7:0] a, input logic [7:0] b,
                                     input logic sub, input logic [1:0] mode);
    exp_t e;
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int ur = sub ? ua - ub : ua + ub;
    int sr = sub ? sa - sb : sa + sb;
    e.result = 8'(ur);
    e.carry  = sub ? (ua < ub) : (ur > 255);
    e.ovf    = (sr > 127) || (sr < -128);
    e.sat    = 1'b0;
    if (mode == 2'b01) begin
      if (!sub && ur > 255) begin e.result = 8'hFF; e.sat = 1'b1; end
      if (sub && ur < 0)    begin e.result = 8'h00; e.sat = 1'b1; end
    end else if (mode == 2'b10) begin
      if (sr > 127)  begin e.result = 8'h7F; e.sat = 1'b1; end
      if (sr < -128) begin e.result = 8'h80; e.sat = 1'b1; end
    end
    e.zero = (e.result == 8'h00);
    e.neg  = e.result[7];
    return e;
  endfunction

  // Compare on the falling edge, then advance the model by the events that
  // the next rising edge will see (inputs are stable from here until then).
  always @(negedge clk) begin
    bit   xfer;
    bit   acc;
    logic front_sat;
    if (primed) begin
      checkOutput("model.out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      checkOutput("model.in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      checkOutput("model.vxsat", 32'(vxsat), 32'(model_vxsat));
      if (exp_q.size() > 0) begin
        checkOutput("model.out_result", 32'(out_result), 32'(exp_q[0].result));
        checkOutput("model.flags", {27'd0, out_carry, out_ovf, out_zero, out_neg, out_sat},
                    {27'd0, exp_q[0].carry, exp_q[0].ovf, exp_q[0].zero, exp_q[0].neg, exp_q[0].sat});
      end
    end
    if (rst) begin
      exp_q.delete();
      model_vxsat = 1'b0;
      primed      = 1'b1;
    end else if (primed) begin
      xfer = (exp_q.size() > 0) && out_ready;
      acc  = in_valid && (exp_q.size() < 2);
      front_sat = 1'b0;
      if (xfer) begin
        front_sat = exp_q[0].sat;
        void'(exp_q.pop_front());
      end
      if (xfer && front_sat) model_vxsat = 1'b1;
      else if (vxsat_clr)    model_vxsat = 1'b0;
      if (acc) exp_q.push_back(modelBeat(cur_a, cur_b, in_sub, in_mode));
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset.vxsat", 32'(vxsat), 32'd0);
    checkOutput("reset.out_result", 32'(out_result), 32'd0);
    checkOutput("reset.flags", {27'd0, out_carry, out_ovf, out_zero, out_neg, out_sat}, 32'd0);

    // Wrap-mode add 0xFF+0x01: sum 0x00 with carry, no signed overflow.
    applyStimulus(1'b1, 8'hFF, 8'h01, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("wrap.out_valid", 32'(out_valid), 32'd1);
    checkOutput("wrap.out_result", 32'(out_result), 32'h00);
    checkOutput("wrap.flags", {27'd0, out_carry, out_ovf, out_zero, out_neg, out_sat}, 32'b10100);
    tick();

    // Signed saturation 0x7F+0x01 clamps to 0x7F; vxsat follows the transfer.
    applyStimulus(1'b1, 8'h7F, 8'h01, 1'b0, 2'b10, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("ssat.out_result", 32'(out_result), 32'h7F);
    checkOutput("ssat.ovf_sat", {30'd0, out_ovf, out_sat}, 32'b11);
    checkOutput("ssat.vxsat_before", 32'(vxsat), 32'd0);
    tick();
    checkOutput("ssat.vxsat_after", 32'(vxsat), 32'd1);

    // Clear alone, then clear racing a saturating transfer.
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    checkOutput("clr.alone", 32'(vxsat), 32'd0);
    applyStimulus(1'b1, 8'h7F, 8'h01, 1'b0, 2'b10, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    checkOutput("clr.vs_sat", 32'(vxsat), 32'd1);

    // Unsigned saturation: 0x03-0x05 -> 0x00, 0xFF+0x02 -> 0xFF.
    applyStimulus(1'b1, 8'h03, 8'h05, 1'b1, 2'b01, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hFF, 8'h02, 1'b0, 2'b01, 1'b1, 1'b0);
    checkOutput("usat.sub_result", 32'(out_result), 32'h00);
    checkOutput("usat.sub_carry_sat", {30'd0, out_carry, out_sat}, 32'b11);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("usat.add_result", 32'(out_result), 32'hFF);
    checkOutput("usat.add_sat", 32'(out_sat), 32'd1);
    tick();

    // Back-pressure: three beats against a stalled output.
    applyStimulus(1'b1, 8'h10, 8'h01, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    checkOutput("bp.ready_after_b1", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 8'h20, 8'h02, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    checkOutput("bp.ready_after_b2", 32'(in_ready), 32'd0);
    checkOutput("bp.hold_b1", 32'(out_result), 32'h11);
    applyStimulus(1'b1, 8'h30, 8'h03, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("bp.b3_stalled", 32'(in_ready), 32'd0);
    checkOutput("bp.still_b1", 32'(out_result), 32'h11);
    applyStimulus(1'b1, 8'h30, 8'h03, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("bp.b2_out", 32'(out_result), 32'h22);
    checkOutput("bp.ready_back", 32'(in_ready), 32'd1);
    tick();
    checkOutput("bp.b3_out", 32'(out_result), 32'h33);
    applyStimulus(1'b1, 8'h40, 8'h04, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("bp.stream_b4", 32'(out_result), 32'h44);
    applyStimulus(1'b1, 8'h50, 8'h05, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("bp.stream_b5", 32'(out_result), 32'h55);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    checkOutput("bp.drained", 32'(out_valid), 32'd0);

    // Fill both entries, then a one-cycle reset with in_valid held high.
    applyStimulus(1'b1, 8'h01, 8'h01, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h02, 8'h02, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    checkOutput("rst.full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h09, 8'h09, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst.vxsat", 32'(vxsat), 32'd0);
    repeat (3) tick();
    checkOutput("rst.no_stale", 32'(out_valid), 32'd0);

    // Randomized traffic; the falling-edge model checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                    1'($urandom), 2'($urandom), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 15) == 0));
      tick();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add_result_stage.md
ADD_RESULT_STAGE -- requirements
Module: add_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the lane width of the upstream ripple_carry_adder result (minimum 2).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_sum  input  WIDTH  adder S.
- in_cout  input  1  adder cout.
- in_prev_cout  input  1  adder prev_cout (carry into MSB).
- in_sub  input  1  beat is a subtract (upstream fed ~B, cin=1).
- in_mode  input  2  00 wrap, 01 unsigned saturate, 10 signed saturate, 11 reserved, treated as 00.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_result  output  WIDTH  final (possibly saturated) result.
- out_carry  output  1  unsigned carry (add) or borrow (sub).
- out_ovf  output  1  signed overflow.
- out_zero  output  1  out_result == 0.
- out_neg  output  1  out_result[WIDTH-1].
- out_sat  output  1  this beat was saturated.
- vxsat_clr  input  1  clear sticky saturation flag.
- vxsat  output  1  sticky saturation flag.

Function
REQ-003 SHALL accept a beat when in_valid && in_ready, and transfer a beat out when out_valid && out_ready.
REQ-004 SHALL compute flags on acceptance: carry = in_sub ? ~in_cout : in_cout; ovf = in_cout ^ in_prev_cout.
REQ-005 Mode 01 SHALL saturate as follows: add with carry=1 -> all ones; sub with borrow=1 -> all zeros; otherwise in_sum.
REQ-006 Mode 10 SHALL saturate as follows: ovf=1 and in_sum[WIDTH-1]=1 -> max positive (0 followed by ones); ovf=1 and in_sum[WIDTH-1]=0 -> min negative (1 followed by zeros); otherwise in_sum.
REQ-007 out_sat SHALL be 1 only when REQ-005/006 replaced in_sum; in modes 00/11 out_sat SHALL be 0 and out_result SHALL equal in_sum.
REQ-008 out_zero and out_neg SHALL be derived from the final out_result, after saturation.
REQ-009 Latency SHALL be exactly 1 cycle: a beat accepted in cycle N appears on out_* in cycle N+1 when the output register is free.
REQ-010 SHALL implement a 2-entry skid buffer: one output register plus one skid register. in_ready SHALL be a registered signal equal to NOT(skid full).
REQ-011 When out_ready=0 with the output register occupied, an accepted beat SHALL go to the skid register; in_ready SHALL drop the next cycle.
REQ-012 When the output beat transfers and the skid register is full, the skid contents SHALL move to the output register the next cycle. in_ready SHALL rise the same cycle the skid register empties.
REQ-013 Simultaneous out transfer and in accept with the skid register empty SHALL load the new beat into the output register directly, with no bubble; sustained throughput SHALL be 1 beat/cycle.
REQ-014 Beats SHALL leave the stage in acceptance order, with none lost or duplicated. out_* SHALL hold stable while out_valid && !out_ready.
REQ-015 vxsat SHALL be set the cycle after a beat with out_sat=1 transfers out, and SHALL remain set until cleared.
REQ-016 vxsat_clr SHALL clear vxsat the next cycle. A simultaneous saturating transfer SHALL win, leaving vxsat=1.

Reset
REQ-017 On rst=1 at a clock edge, the stage SHALL reset: out_valid=0, skid empty, in_ready=1, vxsat=0, out_result=0, and all out flags 0.
REQ-018 Reset asserted mid-operation SHALL discard both buffered beats with no output transfer that cycle. in_valid SHALL be ignored while rst=1.

Verification
REQ-019 Test: WIDTH=8, mode 00, add, in_sum=0x00, in_cout=1, in_prev_cout=1 -> next cycle out_result=0x00, out_carry=1, out_ovf=0, out_zero=1, out_sat=0.
REQ-020 Test: mode 10, add 0x7F+0x01 (in_sum=0x80, cout=0, prev_cout=1) -> out_result=0x7F, out_ovf=1, out_sat=1; vxsat=1 the cycle after transfer.
REQ-021 Test: mode 01, sub 0x03-0x05 (in_sum=0xFE, in_cout=0) -> out_result=0x00, out_carry=1, out_sat=1. Mode 01 add 0xFF+0x02 (in_sum=0x01, cout=1) -> 0xFF.
REQ-022 Test: hold out_ready=0 and send 3 back-to-back beats -> beats 1-2 accepted, in_ready=0 from the cycle after beat 2, beat 3 stalls. Release out_ready -> beats emerge 1,2,3 in order, then 1 beat/cycle.
REQ-023 Test: assert vxsat_clr in the same cycle a saturating beat transfers -> vxsat stays 1. Assert vxsat_clr alone -> vxsat=0 next cycle.
REQ-024 Test: fill both entries, pulse rst for 1 cycle -> out_valid=0, in_ready=1, vxsat=0 next cycle, and no stale beat emerges afterwards.
